// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: EX-to-multiplier issue/response controller.
// Latches one multiply from EX and runs the multiplier start/done handshake.
// A one-entry result cache lets an identical back-to-back multiply skip the
// multiplier. The result goes to writeback while stall_req holds the pipeline.
// Ports: clk, rst (async, active-low); ex_* from EX; flush; wb_stall;
//        stall_req and wb_* to the pipeline; mul_* to and from the multiplier.

package muldiv_pkg;
    typedef enum logic [1:0] {
        m_mul    = 2'd0,
        m_mulh   = 2'd1,
        m_mulhsu = 2'd2,
        m_mulhu  = 2'd3
    } mul_ops;
endpackage

module muldiv_issue_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_mul,
    input  mul_ops          ex_op,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            flush,
    input  logic            wb_stall,
    output logic            stall_req,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            mul_start,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    output mul_ops          mul_op,
    output logic            mul_load_bubble,
    output logic            mul_pipeline_stalled,
    input  logic            mul_ready,
    input  logic [XLEN-1:0] mul_f,
    input  logic            mul_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    mul_ops          op_q, op_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            cache_valid_q, cache_valid_d;
    mul_ops          cache_op_q, cache_op_d;
    logic [XLEN-1:0] cache_a_q, cache_a_d;
    logic [XLEN-1:0] cache_b_q, cache_b_d;
    logic [XLEN-1:0] cache_f_q, cache_f_d;

    logic accept;
    logic hit;

    assign accept = ex_valid & ex_is_mul & ~flush;

    assign hit = cache_valid_q
               & (cache_op_q == ex_op)
               & (cache_a_q == ex_a)
               & (cache_b_q == ex_b);

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        rd_d          = rd_q;
        result_d      = result_q;
        cache_valid_d = cache_valid_q;
        cache_op_d    = cache_op_q;
        cache_a_d     = cache_a_q;
        cache_b_d     = cache_b_q;
        cache_f_d     = cache_f_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d  = ex_a;
                    b_d  = ex_b;
                    op_d = ex_op;
                    rd_d = ex_rd;
                    if (hit) begin
                        result_d = cache_f_q;
                        state_d  = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mul_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mul_done) begin
                    cache_valid_d = 1'b1;
                    cache_op_d    = op_q;
                    cache_a_d     = a_q;
                    cache_b_d     = b_q;
                    cache_f_d     = mul_f;
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        result_d = mul_f;
                        state_d  = S_RESP;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Flushed op still finishes so the multiplier returns idle;
                // its result is only kept in the cache.
                if (mul_done) begin
                    cache_valid_d = 1'b1;
                    cache_op_d    = op_q;
                    cache_a_d     = a_q;
                    cache_b_d     = b_q;
                    cache_f_d     = mul_f;
                    state_d       = S_IDLE;
                end
            end
            S_RESP: begin
                if (flush || !wb_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= m_mul;
            rd_q          <= '0;
            result_q      <= '0;
            cache_valid_q <= 1'b0;
            cache_op_q    <= m_mul;
            cache_a_q     <= '0;
            cache_b_q     <= '0;
            cache_f_q     <= '0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            result_q      <= result_d;
            cache_valid_q <= cache_valid_d;
            cache_op_q    <= cache_op_d;
            cache_a_q     <= cache_a_d;
            cache_b_q     <= cache_b_d;
            cache_f_q     <= cache_f_d;
        end
    end

    // The multiplier's f is combinational on mulop, so its inputs come
    // only from the latched copy, never from EX.
    assign mul_a  = a_q;
    assign mul_b  = b_q;
    assign mul_op = op_q;

    assign mul_start       = (state_q == S_ISSUE) & mul_ready & ~flush;
    assign mul_load_bubble = (state_q != S_ISSUE);

    // Park the multiplier in END only until its result is captured.
    assign mul_pipeline_stalled = ((state_q == S_WAIT) | (state_q == S_DRAIN))
                                & ~mul_done;

    assign stall_req = ((state_q == S_IDLE) & accept)
                     | (state_q == S_ISSUE)
                     | (state_q == S_WAIT)
                     | ((state_q == S_RESP) & wb_stall);

    assign wb_valid = (state_q == S_RESP) & ~flush;
    assign wb_data  = result_q;
    assign wb_rd    = rd_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb_muldiv_issue_ctrl: scoreboard bench for muldiv_issue_ctrl.
// A behavioural iterative multiplier sits on the mul_* port side.

module tb_muldiv_issue_ctrl;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int RD_W = 5;
    localparam int MLAT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ex_valid = 1'b0;
    logic            ex_is_mul = 1'b0;
    mul_ops          ex_op = m_mul;
    logic [XLEN-1:0] ex_a = '0;
    logic [XLEN-1:0] ex_b = '0;
    logic [RD_W-1:0] ex_rd = '0;
    logic            flush = 1'b0;
    logic            wb_stall = 1'b0;
    logic            stall_req;
    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            mul_start;
    logic [XLEN-1:0] mul_a;
    logic [XLEN-1:0] mul_b;
    mul_ops          mul_op;
    logic            mul_load_bubble;
    logic            mul_pipeline_stalled;
    logic            mul_ready;
    logic [XLEN-1:0] mul_f;
    logic            mul_done;

    muldiv_issue_ctrl #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ex_valid             (ex_valid),
        .ex_is_mul            (ex_is_mul),
        .ex_op                (ex_op),
        .ex_a                 (ex_a),
        .ex_b                 (ex_b),
        .ex_rd                (ex_rd),
        .flush                (flush),
        .wb_stall             (wb_stall),
        .stall_req            (stall_req),
        .wb_valid             (wb_valid),
        .wb_rd                (wb_rd),
        .wb_data              (wb_data),
        .mul_start            (mul_start),
        .mul_a                (mul_a),
        .mul_b                (mul_b),
        .mul_op               (mul_op),
        .mul_load_bubble      (mul_load_bubble),
        .mul_pipeline_stalled (mul_pipeline_stalled),
        .mul_ready            (mul_ready),
        .mul_f                (mul_f),
        .mul_done             (mul_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input mul_ops op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            m_mul:    p = ua * ub;
            m_mulh:   p = sa * sb;
            m_mulhsu: p = sa * ub;
            default:  p = ua * ub;
        endcase
        return (op == m_mul) ? p[31:0] : p[63:32];
    endfunction

    // Behavioural multiplier: start -> MLAT busy cycles -> one done cycle.
    logic m_busy;
    logic m_done;
    int   m_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (mul_start) begin
            m_busy <= 1'b1;
            m_cnt  <= MLAT;
        end
    end

    assign mul_ready = ~m_busy & ~m_done;
    assign mul_done  = m_done;
    assign mul_f     = m_done ? ref_mul(mul_op, mul_a, mul_b) : 32'hDEAD_BEEF;

    typedef struct {
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
        bit              hit;
    } exp_t;

    exp_t exp_q[$];

    int cyc = 0;
    int acc_cyc = 0;
    int done_cyc = -100;
    int start_cnt = 0;
    int wb_cnt = 0;
    bit prev_wb = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (mul_start) start_cnt++;
            if (wb_valid && !prev_wb) begin
                if (exp_q.size() > 0) begin
                    if (exp_q[0].hit)
                        chk("lat_hit", 64'(cyc), 64'(acc_cyc + 1));
                    else
                        chk("lat_miss", 64'(cyc), 64'(done_cyc + 1));
                end
            end
            if (wb_valid && !wb_stall) begin
                wb_cnt++;
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_data", 64'(wb_data), 64'(e.data));
                    chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                end
            end
            if (mul_done) done_cyc = cyc;
            prev_wb = wb_valid;
        end else begin
            prev_wb = 1'b0;
        end
    end

    task automatic drive(input mul_ops op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        @(posedge clk);
        #1;
        ex_valid  = 1'b1;
        ex_is_mul = 1'b1;
        ex_op     = op;
        ex_a      = a;
        ex_b      = b;
        ex_rd     = rd;
        acc_cyc   = cyc;
    endtask

    task automatic do_mul(input mul_ops op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input bit hit,
                          input int nstall);
        int s0, w0, scnt;
        logic [31:0] held;
        bit fin;
        drive(op, a, b, rd);
        wb_stall = (nstall > 0);
        exp_q.push_back('{rd: rd, data: exp, hit: hit});
        s0   = start_cnt;
        w0   = wb_cnt;
        scnt = 0;
        fin  = 1'b0;
        held = '0;
        for (int i = 0; i < 60 && !fin; i++) begin
            @(negedge clk);
            if (!wb_valid) begin
                chk("stall_busy", 64'(stall_req), 64'd1);
            end else if (wb_stall) begin
                if (scnt == 0) held = wb_data;
                else chk("stall_data", 64'(wb_data), 64'(held));
                chk("stall_hold", 64'(stall_req), 64'd1);
                scnt++;
                if (scnt == nstall) begin
                    @(posedge clk);
                    #1 wb_stall = 1'b0;
                end
            end else begin
                fin = 1'b1;
            end
        end
        if (!fin) chk("wb_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 ex_valid = 1'b0;
        chk("starts", 64'(start_cnt - s0), hit ? 64'd0 : 64'd1);
        chk("wb_once", 64'(wb_cnt - w0), 64'd1);
    endtask

    task automatic wait_start();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mul_start) seen = 1'b1;
        end
        if (!seen) chk("start_timeout", 64'd0, 64'd1);
    endtask

    task automatic flush_test();
        int w0;
        bit seen;
        w0 = wb_cnt;
        drive(m_mul, 32'd11, 32'd13, 5'd9);
        wait_start();
        @(posedge clk);
        @(posedge clk);
        #1;
        flush    = 1'b1;
        ex_valid = 1'b0;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("drain_stall_req", 64'(stall_req), 64'd0);
        chk("drain_parked", 64'(mul_pipeline_stalled), 64'd1);
        seen = mul_done;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mul_done) seen = 1'b1;
        end
        if (!seen) chk("drain_timeout", 64'd0, 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("drain_ready", 64'(mul_ready), 64'd1);
        chk("drain_no_wb", 64'(wb_cnt - w0), 64'd0);
    endtask

    task automatic reset_test();
        drive(m_mul, 32'd9, 32'd9, 5'd4);
        wait_start();
        @(negedge clk);
        chk("wait_parked", 64'(mul_pipeline_stalled), 64'd1);
        #2;
        rst      = 1'b0;
        ex_valid = 1'b0;
        #1;
        chk("arst_wb_valid", 64'(wb_valid), 64'd0);
        chk("arst_stall", 64'(stall_req), 64'd0);
        chk("arst_start", 64'(mul_start), 64'd0);
        chk("arst_bubble", 64'(mul_load_bubble), 64'd1);
        chk("arst_pstall", 64'(mul_pipeline_stalled), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #1;
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_start", 64'(mul_start), 64'd0);
        chk("rst_bubble", 64'(mul_load_bubble), 64'd1);
        chk("rst_pstall", 64'(mul_pipeline_stalled), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        do_mul(m_mul, 32'd7, 32'd6, 5'd5, 32'h0000_002A, 1'b0, 0);
        do_mul(m_mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,
               32'hFFFF_FFFE, 1'b0, 0);
        do_mul(m_mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,
               32'hFFFF_FFFE, 1'b1, 0);
        do_mul(m_mulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,
               32'h0000_0000, 1'b0, 0);
        do_mul(m_mulhsu, 32'hFFFF_FFFF, 32'd2, 5'd10,
               32'hFFFF_FFFF, 1'b0, 3);

        flush_test();
        do_mul(m_mul, 32'd3, 32'd5, 5'd11, 32'h0000_000F, 1'b0, 0);

        do_mul(m_mul, 32'd7, 32'd6, 5'd12, 32'h0000_002A, 1'b0, 0);
        reset_test();
        do_mul(m_mul, 32'd7, 32'd6, 5'd13, 32'h0000_002A, 1'b0, 0);

        repeat (3) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
